// File: rtl/sum_24bit.sv
// sum_24bit: registered 24-bit adder with a KPG carry-in code.
// Carries come from a Kogge-Stone style parallel-prefix tree over 25 KPG
// entries. Entry 0 is the carry-in and entries 1..24 are operand bits 0..23.
// The result is registered, so latency is exactly one cycle.
module sum_24bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] a,
   input  logic [23:0] b,
   input  logic [1:0]  kIn,
   output logic [24:0] sum
);

   // KPG encoding: kill 2'b00, propagate 2'b01, generate 2'b11.
   // The higher-order code wins unless it propagates; in that case the
   // lower-order code passes through.
   function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
      return (hi == 2'b01) ? lo : hi;
   endfunction

   // One prefix level: each entry at or above 'span' absorbs the entry
   // 'span' positions below it. Lower entries pass through unchanged.
   function automatic logic [49:0] prefix_level(input logic [49:0] v, input int span);
      logic [49:0] r;
      r = v;
      for (int i = 0; i < 25; i++) begin
         if (i >= span) begin
            r[2*i +: 2] = kpg_combine(v[2*i +: 2], v[2*(i-span) +: 2]);
         end
      end
      return r;
   endfunction

   logic [49:0] w_l0;
   logic [49:0] w_l1;
   logic [49:0] w_l2;
   logic [49:0] w_l3;
   logic [49:0] w_l4;
   logic [49:0] w_l5;
   logic [24:0] w_carry;
   logic [24:0] w_sum_next;

   // Leaf codes. The carry-in entry is forced to kill or generate, so the
   // reserved and propagate codes both resolve to a carry-in of 0 and every
   // group code is fully resolved at the top of the tree.
   always_comb begin
      w_l0 = '0;
      w_l0[1:0] = (kIn == 2'b11) ? 2'b11 : 2'b00;
      for (int i = 0; i < 24; i++) begin
         w_l0[2*(i+1) +: 2] = {a[i] & b[i], a[i] | b[i]};
      end
   end

   assign w_l1 = prefix_level(w_l0, 1);
   assign w_l2 = prefix_level(w_l1, 2);
   assign w_l3 = prefix_level(w_l2, 4);
   assign w_l4 = prefix_level(w_l3, 8);
   assign w_l5 = prefix_level(w_l4, 16);

   // Group code at position i spans the carry-in through bit i-1, so
   // 'generate' there is the carry into bit i. Position 24 gives the carry-out.
   always_comb begin
      w_carry = '0;
      for (int i = 0; i < 25; i++) begin
         w_carry[i] = w_l5[2*i+1] & w_l5[2*i];
      end
   end

   assign w_sum_next = {w_carry[24], a ^ b ^ w_carry[23:0]};

   // Output register. Reset clears it at once, which also discards any
   // result still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum <= '0;
      end else begin
         sum <= w_sum_next;
      end
   end

endmodule

// File: tb/tb_sum_24bit.sv
// Bench for sum_24bit. A reference model computes a + b + cin with plain
// arithmetic. It is checked every negedge against the DUT, and directed
// literal cases pin both the model and the DUT.
module tb_sum_24bit;

   logic        clk;
   logic        rst_n;
   logic [23:0] a;
   logic [23:0] b;
   logic [1:0]  kIn;
   logic [24:0] sum;

   int total = 0;
   int bad   = 0;
   logic        chk_en = 1'b0;
   logic [24:0] m_exp;

   sum_24bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .a     (a),
      .b     (b),
      .kIn   (kIn),
      .sum   (sum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: the result expected after the most recent capture edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_exp <= 25'h0;
      else        m_exp <= {1'b0, a} + {1'b0, b} + ((kIn == 2'b11) ? 25'd1 : 25'd0);
   end

   task automatic chk(input string name, input logic [24:0] act, input logic [24:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (a=%h b=%h kIn=%b)", name, act, exp, a, b, kIn);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) chk("model", sum, m_exp);
   end

   // Drive one operand set, then check the result one cycle later against a literal.
   task automatic lit(input string name, input logic [23:0] ta, input logic [23:0] tb,
                      input logic [1:0] tk, input logic [24:0] exp);
      @(negedge clk);
      a = ta; b = tb; kIn = tk;
      @(posedge clk);
      #1;
      chk(name, sum, exp);
      chk({name, "_model"}, m_exp, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, expected finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a = 24'hABCDEF; b = 24'h123456; kIn = 2'b11;
      #1;
      chk("reset_now", sum, 25'h0);
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("reset_hold", sum, 25'h0);
      end
      // Deassert between edges. The first rising edge must capture the current inputs.
      @(negedge clk);
      a = 24'h000001; b = 24'h000002; kIn = 2'b00;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("first_after_reset", sum, 25'h0000003);
      chk_en = 1'b1;

      lit("vec_k00",     24'h8C6315, 24'h5AD6BB, 2'b00, 25'h0E739D0);
      lit("vec_k11",     24'h8C6315, 24'h5AD6BB, 2'b11, 25'h0E739D1);
      lit("ripple_k11",  24'hFFFFFF, 24'h000000, 2'b11, 25'h1000000);
      lit("ripple_k01",  24'hFFFFFF, 24'h000000, 2'b01, 25'h0FFFFFF);
      lit("ripple_k10",  24'hFFFFFF, 24'h000000, 2'b10, 25'h0FFFFFF);
      lit("ones_k11",    24'hFFFFFF, 24'hFFFFFF, 2'b11, 25'h1FFFFFF);
      lit("zero_k00",    24'h000000, 24'h000000, 2'b00, 25'h0000000);
      lit("ripple_b",    24'h000000, 24'hFFFFFF, 2'b11, 25'h1000000);
      lit("carry_out",   24'h800000, 24'h800000, 2'b00, 25'h1000000);

      // A mid-cycle reset discards the result in flight.
      @(negedge clk);
      a = 24'h123456; b = 24'h111111; kIn = 2'b11;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("reset_mid", sum, 25'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_mid_reset", sum, 25'h0234568);

      // Random back-to-back stream. Every cycle is checked by the model compare.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         a   = 24'($urandom);
         b   = 24'($urandom);
         kIn = 2'($urandom_range(0, 3));
      end
      @(negedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sum_24bit.md
SUM_24BIT -- requirements
Module: sum_24bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  rising-edge clock for the output register.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset; clears the output register.
REQ-004 Port: a  input  24  unsigned addend A.
REQ-005 Port: b  input  24  unsigned addend B.
REQ-006 Port: kIn  input  2  carry-in as a KPG code: 2'b00 kill, 2'b01 propagate, 2'b11 generate, 2'b10 reserved.
REQ-007 Port: sum  output  25  registered result; sum[23:0] is the sum bits, sum[24] is the carry-out.
REQ-008 The block SHALL have no parameters; all widths are fixed as listed.

Function
REQ-009 Carry-in SHALL be 1 only for kIn = 2'b11; kIn = 2'b00, 2'b01 and 2'b10 SHALL all give carry-in 0.
REQ-010 Per bit i (0..23), the block SHALL form a KPG code from a[i], b[i]:
  - kill 2'b00 when both bits are 0
  - propagate 2'b01 when exactly one bit is 1
  - generate 2'b11 when both bits are 1
REQ-011 The carry-in code SHALL sit at prefix position 0 and bits 0..23 at positions 1..24, giving a 25-entry code vector.
REQ-012 KPG combine (higher o lower) SHALL be:
  - higher kill -> kill
  - higher generate -> generate
  - higher propagate -> the lower code
REQ-013 Carries SHALL be computed by a log-depth parallel-prefix tree over the 25 entries, with levels at spans 1, 2, 4, 8 and 16.
REQ-014 After the prefix, each position's group code SHALL resolve to kill or generate; generate means carry 1.
REQ-015 sum[i] SHALL equal a[i] XOR b[i] XOR carry-into-bit-i for i = 0..23.
REQ-016 sum[24] SHALL equal the carry out of bit 23.
REQ-017 The result SHALL always equal a + b + cin, modulo 2^25, with no overflow flag.
REQ-018 Prefix logic SHALL be combinational; sum SHALL be captured on the rising clk edge, giving latency exactly 1 cycle.
REQ-019 A new operand set SHALL be accepted every cycle, with no handshake and no stall.
REQ-020 Input changes between edges SHALL NOT affect sum until the next rising edge.
REQ-021 Boundaries:
  - a = b = 0 with cin 0 -> 0
  - all-ones operands with cin 1 -> 25'h1FFFFFF
  - a full ripple carry (0xFFFFFF + 1) SHALL resolve within the same cycle

Reset
REQ-022 While rst_n = 0, sum SHALL be 25'h0000000 immediately, independent of clk.
REQ-023 Assertion of rst_n mid-operation SHALL discard the result in flight.
REQ-024 After rst_n deasserts, the first rising clk edge SHALL capture the current a, b, kIn.
REQ-025 There is no other internal state.

Verification
REQ-026 Reset: rst_n = 0 with any inputs -> sum = 0 at once, held until after deassertion.
REQ-027 a = 0x8C6315, b = 0x5AD6BB, kIn = 00 -> sum = 0x0E739D0 one cycle later; same operands with kIn = 11 -> 0x0E739D1.
REQ-028 Ripple and carry-in codes:
  - a = 0xFFFFFF, b = 0x000000, kIn = 11 -> sum = 0x1000000 (full ripple, carry-out set)
  - kIn = 01 or 10 with those operands -> 0x0FFFFFF
REQ-029 a = b = 0xFFFFFF, kIn = 11 -> 0x1FFFFFF; a = b = 0, kIn = 00 -> 0x0000000.
REQ-030 Throughput: a different operand pair each cycle -> each result appears exactly one cycle after its operands; compare every cycle against a + b + cin.
REQ-031 Random regression: at least 10000 random (a, b, kIn) triples -> sum matches the reference model.
